// File: rtl/plab4_net_router_output_tdm_ctrl.sv
// Output-port controller for the ring router: round-robin arbitration
// gated by a data-independent time-division schedule over security domains.
module plab4_net_router_output_tdm_ctrl #(
   parameter int p_num_domains  = 2,
   parameter int p_domain_nbits = 1,
   parameter int p_turn_cycles  = 4,
   parameter int p_dead_cycles  = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [2:0]                  reqs,
   input  logic [3*p_domain_nbits-1:0] req_domains,
   output logic [2:0]                  grants,
   output logic                        out_val,
   input  logic                        out_rdy,
   output logic [1:0]                  xbar_sel,
   output logic [p_domain_nbits-1:0]   cur_domain
);

   localparam logic [7:0] c_last_cnt = 8'(p_turn_cycles - 1);
   localparam logic [8:0] c_dead_start =
      9'(p_turn_cycles - p_dead_cycles);
   localparam logic [p_domain_nbits-1:0] c_last_dom =
      p_domain_nbits'(p_num_domains - 1);

   logic [7:0]                r_turn_cnt;
   logic [p_domain_nbits-1:0] r_dom;
   logic [2:0]                r_prio;

   logic       w_dead;
   logic [2:0] w_elig;
   logic [2:0] w_arb;
   logic       w_xfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_turn_cnt <= 8'd0;
         r_dom      <= '0;
         r_prio     <= 3'b001;
      end else begin
         if (r_turn_cnt == c_last_cnt) begin
            r_turn_cnt <= 8'd0;
            r_dom      <= (r_dom == c_last_dom) ? '0 : r_dom + 1'b1;
         end else begin
            r_turn_cnt <= r_turn_cnt + 8'd1;
         end
         // Pointer moves one past the winner only on a real transfer
         if (w_xfer)
            r_prio <= {w_arb[1:0], w_arb[2]};
      end
   end

   // 9-bit compare so a zero-length dead window never matches
   assign w_dead = ({1'b0, r_turn_cnt} >= c_dead_start);

   always_comb begin
      w_elig = 3'b000;
      for (int i = 0; i < 3; i++) begin
         w_elig[i] = reqs[i] & ~w_dead &
            (req_domains[i*p_domain_nbits +: p_domain_nbits] == r_dom);
      end
   end

   always_comb begin
      w_arb = 3'b000;
      case (r_prio)
         3'b010: begin
            if      (w_elig[1]) w_arb = 3'b010;
            else if (w_elig[2]) w_arb = 3'b100;
            else if (w_elig[0]) w_arb = 3'b001;
         end
         3'b100: begin
            if      (w_elig[2]) w_arb = 3'b100;
            else if (w_elig[0]) w_arb = 3'b001;
            else if (w_elig[1]) w_arb = 3'b010;
         end
         default: begin
            if      (w_elig[0]) w_arb = 3'b001;
            else if (w_elig[1]) w_arb = 3'b010;
            else if (w_elig[2]) w_arb = 3'b100;
         end
      endcase
   end

   assign w_xfer = (|w_arb) & out_rdy;

   always_comb begin
      out_val  = 1'b0;
      grants   = 3'b000;
      xbar_sel = 2'd0;
      if (!reset) begin
         out_val = |w_arb;
         grants  = w_arb & {3{out_rdy}};
         if (w_arb[1])
            xbar_sel = 2'd1;
         else if (w_arb[2])
            xbar_sel = 2'd2;
      end
   end

   assign cur_domain = r_dom;

endmodule

// File: tb/tb_plab4_net_router_output_tdm_ctrl.sv
// Bench for the TDM output controller: two parameterisations driven in
// lockstep, expected outputs queued by a schedule model and checked at negedge.
module tb_plab4_net_router_output_tdm_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       out_rdy;
   logic [2:0] reqs_a, reqs_b;
   logic [2:0] dom_a;
   logic [5:0] dom_b;
   logic [2:0] grants_a, grants_b;
   logic       val_a, val_b;
   logic [1:0] sel_a, sel_b;
   logic [0:0] cd_a;
   logic [1:0] cd_b;

   plab4_net_router_output_tdm_ctrl dut_a (
      .clk         (clk),
      .reset       (reset),
      .reqs        (reqs_a),
      .req_domains (dom_a),
      .grants      (grants_a),
      .out_val     (val_a),
      .out_rdy     (out_rdy),
      .xbar_sel    (sel_a),
      .cur_domain  (cd_a)
   );

   plab4_net_router_output_tdm_ctrl #(
      .p_num_domains  (2),
      .p_domain_nbits (2),
      .p_turn_cycles  (6),
      .p_dead_cycles  (2)
   ) dut_b (
      .clk         (clk),
      .reset       (reset),
      .reqs        (reqs_b),
      .req_domains (dom_b),
      .grants      (grants_b),
      .out_val     (val_b),
      .out_rdy     (out_rdy),
      .xbar_sel    (sel_b),
      .cur_domain  (cd_b)
   );

   typedef struct {
      logic [2:0] ga, gb;
      logic       va, vb;
      logic [1:0] sa, sb;
      int         da, db;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int m_cyc = 0;
   int m_pa = 0;
   int m_pb = 0;

   // Schedule derived from cycles since reset; prio kept as an index
   function automatic void model(
      input int cyc, input int p, input int T, input int Dd, input int N,
      input logic [2:0] rq, input int d0, input int d1, input int d2,
      input logic rst, input logic rdy,
      output logic [2:0] g, output logic v, output logic [1:0] s,
      output int dom, output int gidx);
      int tc = cyc % T;
      int dm = (cyc / T) % N;
      int d[3];
      d = '{d0, d1, d2};
      gidx = -1;
      for (int k = 0; k < 3; k++) begin
         int i = (p + k) % 3;
         if (gidx < 0 && rq[i] && d[i] == dm && tc < T - Dd)
            gidx = i;
      end
      dom = dm;
      g = 3'b000;
      v = 1'b0;
      s = 2'd0;
      if (!rst && gidx >= 0) begin
         v = 1'b1;
         s = 2'(gidx);
         if (rdy) g = 3'(1 << gidx);
      end
   endfunction

   task automatic step(
      input logic rst, input logic rdy,
      input logic [2:0] ra, input int a0, input int a1, input int a2,
      input logic [2:0] rb, input int b0, input int b1, input int b2);
      exp_t e;
      int gia, gib;
      reset   = rst;
      out_rdy = rdy;
      reqs_a  = ra;
      dom_a   = {a2[0], a1[0], a0[0]};
      reqs_b  = rb;
      dom_b   = {b2[1:0], b1[1:0], b0[1:0]};
      model(m_cyc, m_pa, 4, 1, 2, ra, a0, a1, a2, rst, rdy,
            e.ga, e.va, e.sa, e.da, gia);
      model(m_cyc, m_pb, 6, 2, 2, rb, b0, b1, b2, rst, rdy,
            e.gb, e.vb, e.sb, e.db, gib);
      q.push_back(e);
      @(posedge clk);
      #1;
      if (rst) begin
         m_cyc = 0;
         m_pa  = 0;
         m_pb  = 0;
      end else begin
         m_cyc++;
         if (e.va && rdy) m_pa = (gia + 1) % 3;
         if (e.vb && rdy) m_pb = (gib + 1) % 3;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("grants_a", 32'(grants_a), 32'(e.ga));
            chk("out_val_a", 32'(val_a), 32'(e.va));
            chk("xbar_sel_a", 32'(sel_a), 32'(e.sa));
            chk("cur_domain_a", 32'(cd_a), 32'(e.da));
            chk("grants_b", 32'(grants_b), 32'(e.gb));
            chk("out_val_b", 32'(val_b), 32'(e.vb));
            chk("xbar_sel_b", 32'(sel_b), 32'(e.sb));
            chk("cur_domain_b", 32'(cd_b), 32'(e.db));
         end
      end
   end

   initial begin : stim
      reset   = 1'b1;
      out_rdy = 1'b0;
      reqs_a  = 3'b000;
      reqs_b  = 3'b000;
      dom_a   = '0;
      dom_b   = '0;
      repeat (2) @(posedge clk);
      #1;
      m_cyc = 0;
      m_pa  = 0;
      m_pb  = 0;
      step(1, 1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
      // round-robin within turn, dead cycle, foreign turn
      repeat (8) step(0, 1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
      // domain gating
      repeat (12) step(0, 1, 3'b011, 1, 0, 0, 3'b011, 1, 0, 0);
      // backpressure then release
      repeat (5) step(0, 0, 3'b101, 0, 0, 0, 3'b101, 1, 0, 1);
      repeat (6) step(0, 1, 3'b101, 0, 0, 0, 3'b101, 1, 0, 1);
      // single held request across dead windows
      repeat (24) step(0, 1, 3'b010, 0, 1, 0, 3'b010, 0, 0, 0);
      // out-of-range domains
      repeat (16) step(0, 1, 3'b111, 0, 1, 1, 3'b111, 2, 3, 2);
      // reset mid-turn, then all requesting
      repeat (6) step(0, 1, 3'b111, 1, 1, 1, 3'b111, 1, 1, 1);
      step(1, 1, 3'b111, 1, 1, 1, 3'b111, 1, 1, 1);
      repeat (6) step(0, 1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
              3'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1),
              3'($urandom), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 2));
      end
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
